// File: rtl/bist_response_misr.sv
// Response compactor for combinational benchmark outputs: folds each accepted
// response into a MISR signature and compares it against a golden value at the end of a run.
module bist_response_misr #(
   parameter int                 WIDTH   = 32,
   parameter logic [WIDTH-1:0]   POLY    = 32'h04C11DB7,
   parameter logic [WIDTH-1:0]   SEED    = 32'h00000000,
   parameter int                 COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [COUNT_W-1:0] num_patterns,
   input  logic [WIDTH-1:0]   golden_sig,
   input  logic               resp_valid,
   input  logic [WIDTH-1:0]   resp_data,
   output logic               resp_ready,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [WIDTH-1:0]   signature,
   output logic [COUNT_W-1:0] pat_count
);

   // state | meaning
   // IDLE  | no run active; waiting for start
   // RUN   | accepting responses into the signature
   // DONE  | run complete; signature compared against golden_sig
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [COUNT_W-1:0] num_latched;
   logic               accept;
   logic               last_accept;
   logic               start_ok;
   logic [WIDTH-1:0]   sig_step;

   assign accept      = (state == RUN) && resp_valid && !abort;
   assign last_accept = accept && (pat_count == num_latched - COUNT_W'(1));
   assign start_ok    = start && ((state == IDLE) || (state == DONE));
   assign sig_step    = {signature[WIDTH-2:0], 1'b0}
                        ^ (signature[WIDTH-1] ? POLY : '0)
                        ^ resp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = (num_patterns != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (last_accept) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An abort leaves signature and count untouched so the partial run can be inspected.
   always_ff @(posedge clk) begin
      if (rst) begin
         signature   <= SEED;
         pat_count   <= '0;
         num_latched <= '0;
      end else if (start_ok) begin
         signature   <= SEED;
         pat_count   <= '0;
         num_latched <= num_patterns;
      end else if (accept) begin
         signature   <= sig_step;
         pat_count   <= pat_count + COUNT_W'(1);
      end
   end

   assign resp_ready = (state == RUN);
   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign pass       = done && (signature == golden_sig);

endmodule
